// File: rtl/sram_like_responder.sv
// SRAM-like bus responder: in-order queue of up to MAX_OUT requests, data_ok LATENCY cycles after accept.
// Optional SRAM_RAND_STALL_EN adds an LFSR that randomly withholds addr_ok.
module sram_like_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_OUT    = 2,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int NW    = $clog2(MAX_OUT + 1);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [31:0]   data;
  } entry_t;

  logic [31:0]           mem [WORDS];
  entry_t                r_q [MAX_OUT];
  logic [PW-1:0]         r_wp, r_rp;
  logic [NW-1:0]         r_count;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_full, w_pop, w_cap_ok, w_acc;
  logic                  w_unused;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_idx    = addr[DEPTH_LOG2+1:2];
  assign w_full   = (r_count == NW'(MAX_OUT));
  assign w_pop    = (r_count != '0) && (r_q[r_rp].cnt == '0);
  assign w_cap_ok = !w_full || w_pop;
  assign w_acc    = req && addr_ok;
  assign w_unused = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef SRAM_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci taps 16,14,13,11; newest bit lands in bit 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= 16'hACE1;
    else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign addr_ok = w_cap_ok && r_lfsr[0];
`else
  assign addr_ok = w_cap_ok;
`endif

  assign data_ok = w_pop;
  assign rdata   = w_pop ? r_q[r_rp].data : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < MAX_OUT; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++)
        if (r_q[i].cnt != '0) r_q[i].cnt <= r_q[i].cnt - CW'(1);
      // the freshly pushed slot overrides the decrement above
      if (w_acc) begin
        r_q[r_wp].cnt  <= CW'(LATENCY - 1);
        r_q[r_wp].data <= wr ? 32'h0 : mem[w_idx];
        r_wp           <= f_inc(r_wp);
      end
      if (w_pop) r_rp <= f_inc(r_rp);
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // memory content is deliberately not reset so the bench can preload it
  always_ff @(posedge clk) begin
    if (resetn && w_acc && wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: reference memory + response queue scoreboard.
module tb_sram_like_responder;
  localparam int DEPTH_LOG2 = 10;
  localparam int MAX_OUT    = 2;
  localparam int LATENCY    = 2;

  logic        clk = 1'b0;
  logic        resetn, req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  sram_like_responder #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_OUT(MAX_OUT), .LATENCY(LATENCY)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [1 << DEPTH_LOG2];
  logic [15:0] m_lfsr;
  int          cyc, checks, failures;
  logic        acc;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // called mid-cycle: compare outputs against the model, then record any accept
  task automatic sample();
    logic due, exp_aok;
    exp_t e;
    logic [DEPTH_LOG2-1:0] idx;
    due     = (sb.size() != 0) && (sb[0].due == cyc);
    exp_aok = (sb.size() < MAX_OUT) || due;
`ifdef SRAM_RAND_STALL_EN
    exp_aok = exp_aok && m_lfsr[0];
`endif
    chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
    chk("data_ok", 32'(data_ok), 32'(due));
    if (due) begin
      e = sb.pop_front();
      chk("rdata", rdata, e.data);
      last_rdata = rdata;
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
    acc = req && addr_ok;
    if (acc) begin
      idx = addr[DEPTH_LOG2+1:2];
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        e.data = 32'h0;
      end else begin
        e.data = m_mem[idx];
      end
      e.due = cyc + LATENCY;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    #1 sample();
    @(posedge clk);
    if (resetn) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    cyc++;
    @(negedge clk);
  endtask

  // hold req until accepted, bounded
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) tick();
    chk("accept_timeout", 32'(acc), 32'h1);
  endtask

  task automatic drain();
    req = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    tick();
    chk("drain_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; last_rdata = '0; acc = 1'b0;
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = '0; wdata = '0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
      m_mem[i]   = 32'hC0DE_0000 ^ (i * 32'h0001_0203);
      dut.mem[i] = m_mem[i];
    end
    m_mem[4] = 32'h1234_5678; dut.mem[4] = 32'h1234_5678;
    m_mem[8] = 32'h0;         dut.mem[8] = 32'h0;

    #12;
    chk("reset_data_ok", 32'(data_ok), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr_ok", 32'(addr_ok), 32'h1);
    @(negedge clk); resetn = 1'b1;

    // single read, isolated
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    drain();
    chk("single_read", last_rdata, 32'h1234_5678);

    // queue full with req held high
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    drain();

    // write then read same word on the next cycle
    issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    drain();
    chk("raw_read", last_rdata, 32'h0000_CCDD);

    // aliased upper address bits hit the same word
    issue(1'b1, 32'h7000_0024, 32'hDEAD_BEEF, 4'b1100);
    issue(1'b0, 32'h0000_0024, 32'h0, 4'h0);
    drain();
    chk("alias_read", last_rdata[31:16], 32'hDEAD);

    // random mixed traffic, back to back
    for (int n = 0; n < 24; n++)
      issue(1'($urandom_range(0, 1)),
            (32'($urandom_range(0, 15)) << 28) | (32'($urandom_range(0, 63)) << 2),
            $urandom, 4'($urandom_range(0, 15)));
    drain();

    // reset mid-flight: two reads in flight, async reset mid-cycle
    req = 1'b1; wr = 1'b0; addr = 32'h10; acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) tick();
    chk("mf_accept1", 32'(acc), 32'h1);
    addr = 32'h14;
    #1 sample();
    chk("mf_accept2", 32'(acc), 32'h1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mf_reset_data_ok", 32'(data_ok), 32'h0);
    chk("mf_reset_rdata", rdata, 32'h0);
    sb.delete();
    m_lfsr = 16'hACE1;
    req = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 5; k++) tick();

`ifdef SRAM_RAND_STALL_EN
    // req held high: accept pattern must follow the LFSR reference
    req = 1'b1; wr = 1'b0;
    for (int k = 0; k < 64; k++) begin
      addr = 32'($urandom_range(0, 1023)) << 2;
      tick();
    end
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
